// File: rtl/step_clock_pkg.sv
// Shared types and width helpers for the step clock generator.
package step_clock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HIGH     = 2'd1,
    LOW_HOLD = 2'd2
  } state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_clock_gen_key_debounce.sv
// Step key synchronizer and debouncer. The debounced state resets to
// released (1); press is a one-cycle strobe on an accepted 1->0 change.
module key_debounce
  import step_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   stable_q;
  logic                   key_sync;
  logic                   flip;

  assign key_sync = sync_q[SYNC_STAGES-1];
  // The sampled level has disagreed with the stable state long enough.
  assign flip     = (key_sync != stable_q) && (cnt_q == CNT_LAST);
  // Strobe in the same cycle the stable state falls, so the FSM reacts
  // on the edge that commits the new level.
  assign press    = flip && stable_q;

  // Synchronizer chain; idles at the released level.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
  end

  // Debounce counter: restarts whenever the input agrees with the stable state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b1;
    end else if (key_sync == stable_q) begin
      cnt_q    <= '0;
    end else if (flip) begin
      stable_q <= key_sync;
      cnt_q    <= '0;
    end else begin
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/step_clock_gen.sv
// Processor clock source: one clean cpu_clk pulse per debounced key press,
// or periodic pulses in auto-run mode. cpu_clk comes straight from a flop.
//
// Handshake: there is no valid/ready pair here; a request (press strobe or
// auto-run tick) is a one-cycle event. It is accepted in IDLE, parked in a
// one-deep pending flag while busy, and dropped if the flag is already set.
module step_clock_gen
  import step_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2,
  parameter int CLK_HIGH_CYCLES = 4,
  parameter int CLK_LOW_CYCLES  = 4,
  parameter int BASE_PERIOD     = 50_000_000,
  parameter int STEP_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_n,
  input  logic              run_en,
  input  logic [2:0]        rate_sel,
  output logic              cpu_clk,
  output logic              step_pulse,
  output logic              busy,
  output logic [STEP_W-1:0] step_count,
  output state_t            state_dbg
);

  localparam int DW  = cnt_w(BASE_PERIOD);
  localparam int PW  = DW + 1;
  localparam int PHW = cnt_w(max2(CLK_HIGH_CYCLES, CLK_LOW_CYCLES));
  localparam logic [PW-1:0]  BASE      = PW'(BASE_PERIOD);
  localparam logic [PHW-1:0] HIGH_LAST = PHW'(CLK_HIGH_CYCLES - 1);
  localparam logic [PHW-1:0] LOW_LAST  = PHW'(CLK_LOW_CYCLES - 1);

  logic                   press;
  logic [SYNC_STAGES-1:0] run_q;
  logic                   run_sync;
  logic [DW-1:0]          div_q;
  logic [PW-1:0]          period;
  logic [PW-1:0]          term;
  logic                   tick;
  logic                   req;

  state_t                 state_q, state_n;
  logic [PHW-1:0]         phase_q, phase_n;
  logic                   pending_q, pending_n;
  logic                   cpu_clk_n, pulse_n;
  logic [STEP_W-1:0]      count_n;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_key (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .press (press)
  );

  // run_en synchronizer; idles in manual mode.
  always_ff @(posedge clk) begin
    if (reset) run_q <= '0;
    else       run_q <= {run_q[SYNC_STAGES-2:0], run_en};
  end
  assign run_sync = run_q[SYNC_STAGES-1];

  // Terminal count for the selected rate; a zero period behaves as one.
  always_comb begin
    period = BASE >> rate_sel;
    term   = (period == '0) ? '0 : period - PW'(1);
  end

  // >= lets a divider already past a newly lowered terminal wrap at once.
  assign tick = run_sync && ({1'b0, div_q} >= term);
  assign req  = run_sync ? tick : press;

  // Auto-run divider, parked at zero in manual mode.
  always_ff @(posedge clk) begin
    if (reset || !run_sync) div_q <= '0;
    else if (tick)          div_q <= '0;
    else                    div_q <= div_q + DW'(1);
  end

  // Pulse FSM next-state, output and pending-flag logic.
  always_comb begin
    state_n   = state_q;
    phase_n   = phase_q;
    pending_n = pending_q;
    cpu_clk_n = cpu_clk;
    pulse_n   = 1'b0;
    count_n   = step_count;
    case (state_q)
      IDLE: begin
        if (req || pending_q) begin
          state_n   = HIGH;
          phase_n   = '0;
          cpu_clk_n = 1'b1;
          pulse_n   = 1'b1;
          count_n   = step_count + STEP_W'(1);
          pending_n = 1'b0;
        end
      end
      HIGH: begin
        if (req) pending_n = 1'b1;
        if (phase_q == HIGH_LAST) begin
          state_n   = LOW_HOLD;
          phase_n   = '0;
          cpu_clk_n = 1'b0;
        end else begin
          phase_n   = phase_q + PHW'(1);
        end
      end
      LOW_HOLD: begin
        if (req) pending_n = 1'b1;
        if (phase_q == LOW_LAST) begin
          state_n   = IDLE;
          phase_n   = '0;
        end else begin
          phase_n   = phase_q + PHW'(1);
        end
      end
      default: begin
        state_n   = IDLE;
        phase_n   = '0;
        cpu_clk_n = 1'b0;
      end
    endcase
  end

  // Pulse FSM registers; reset drops cpu_clk on the very next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      pending_q  <= 1'b0;
      cpu_clk    <= 1'b0;
      step_pulse <= 1'b0;
      step_count <= '0;
    end else begin
      state_q    <= state_n;
      phase_q    <= phase_n;
      pending_q  <= pending_n;
      cpu_clk    <= cpu_clk_n;
      step_pulse <= pulse_n;
      step_count <= count_n;
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_step_clock_gen.sv
// Directed bench for step_clock_gen with short debounce and divider settings.
module tb_step_clock_gen;
  import step_clock_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_n;
  logic        run_en;
  logic [2:0]  rate_sel;
  logic        cpu_clk;
  logic        step_pulse;
  logic        busy;
  logic [15:0] step_count;
  state_t      state_dbg;

  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  logic [31:0] cyc = '0;
  logic [31:0] c0;
  logic [31:0] exp_q[$];

  step_clock_gen #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2),
    .CLK_HIGH_CYCLES (2),
    .CLK_LOW_CYCLES  (2),
    .BASE_PERIOD     (64),
    .STEP_W          (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .run_en     (run_en),
    .rate_sel   (rate_sel),
    .cpu_clk    (cpu_clk),
    .step_pulse (step_pulse),
    .busy       (busy),
    .step_count (step_count),
    .state_dbg  (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every step_pulse is matched against the next expected cycle.
  always @(negedge clk) begin
    logic [31:0] e;
    if (step_pulse === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    pulse_cnt = 0;
    exp_q.delete();
  endtask

  task automatic end_test(input string tag, input int n_pulses);
    check({tag, "_pulses"}, pulse_cnt, n_pulses);
    check({tag, "_unmatched"}, exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; key_n = 1'b0; run_en = 1'b0; rate_sel = 3'd0;

    // Reset held 3 cycles with the key down: everything stays quiet.
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("rst_out", {cpu_clk, step_pulse, busy, step_count}, 0);
      check("rst_state", state_dbg, IDLE);
    end
    key_n = 1'b1; reset = 1'b0;
    pulse_cnt = 0;
    step(20);
    check("rst_count", step_count, 0);
    end_test("rst", 0);

    // Single clean press: pulse 2 sync + 4 debounce cycles after the fall.
    do_reset();
    c0 = cyc; key_n = 1'b0;
    exp_q.push_back(c0 + 6);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k == 6) check("press_clk_hi0", {cpu_clk, step_pulse, busy}, 3'b111);
      if (k == 7) check("press_clk_hi1", {cpu_clk, step_pulse, busy}, 3'b101);
      if (k == 8) check("press_clk_lo0", {cpu_clk, busy}, 2'b01);
      if (k == 10) check("press_idle", {cpu_clk, busy}, 2'b00);
    end
    key_n = 1'b1;
    step(12);
    check("press_count", step_count, 1);
    end_test("press", 1);

    // Bouncy press: toggles every 2 cycles for 12 cycles, then held low.
    do_reset();
    c0 = cyc;
    exp_q.push_back(c0 + 18);
    for (int k = 0; k < 32; k++) begin
      key_n = (k < 12) ? ((k % 4) >= 2) : 1'b0;
      step(1);
    end
    key_n = 1'b1;
    step(12);
    check("bounce_count", step_count, 1);
    end_test("bounce", 1);

    // Auto-run at rate_sel=2: ticks every 16 cycles; key presses ignored.
    do_reset();
    c0 = cyc; run_en = 1'b1; rate_sel = 3'd2;
    for (int i = 0; i < 4; i++) exp_q.push_back(c0 + 18 + 16 * i);
    for (int k = 1; k <= 66; k++) begin
      if (k == 20) key_n = 1'b0;
      if (k == 40) key_n = 1'b1;
      step(1);
      if (k == 17) check("auto_before_first", step_count, 0);
    end
    check("auto_count", step_count, 4);
    run_en = 1'b0;
    step(12);
    check("auto_count_after", step_count, 4);
    end_test("auto", 4);

    // Back-to-back at period 1: one pulse every 5 cycles. The pending
    // request latched before run_en drops still produces one more pulse.
    do_reset();
    c0 = cyc; run_en = 1'b1; rate_sel = 3'd6;
    for (int i = 0; i < 7; i++) exp_q.push_back(c0 + 3 + 5 * i);
    step(30);
    check("b2b_count_mid", step_count, 6);
    run_en = 1'b0;
    step(15);
    check("b2b_count_end", step_count, 7);
    check("b2b_idle", busy, 0);
    end_test("b2b", 7);

    // Counter wrap from a preloaded value.
    do_reset();
    force dut.step_count = 16'hFFFE;
    step(1);
    release dut.step_count;
    step(1);
    check("wrap_preload", step_count, 16'hFFFE);
    c0 = cyc; run_en = 1'b1; rate_sel = 3'd6;
    for (int i = 0; i < 3; i++) exp_q.push_back(c0 + 3 + 5 * i);
    for (int k = 1; k <= 20; k++) begin
      if (k == 9) run_en = 1'b0;
      step(1);
      if (k == 3) check("wrap_ffff", step_count, 16'hFFFF);
      if (k == 8) check("wrap_zero", step_count, 16'h0000);
    end
    check("wrap_final", step_count, 16'h0001);
    end_test("wrap", 3);

    // Reset on the 2nd HIGH cycle: cpu_clk/busy drop next edge, pending lost.
    do_reset();
    c0 = cyc; run_en = 1'b1; rate_sel = 3'd6;
    exp_q.push_back(c0 + 3);
    step(4);
    check("midrst_high", {cpu_clk, busy}, 2'b11);
    reset = 1'b1; run_en = 1'b0;
    step(1);
    check("midrst_out", {cpu_clk, step_pulse, busy, step_count}, 0);
    check("midrst_state", state_dbg, IDLE);
    reset = 1'b0;
    step(15);
    check("midrst_count", step_count, 0);
    end_test("midrst", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_clock_gen.md
Name: step_clock_gen

Overview:
- Generates the processor clock for the single-cycle MIPS on the DE2-115 board.
- Replaces the raw inverted push-button as the core clock source.
- Synchronizes and debounces the step key, so one physical press gives exactly one clean processor clock pulse.
- Offers an auto-run mode at a switch-selectable rate.
- Runs on CLOCK_50; its cpu_clk output drives the processor clk input.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: cycles the synchronized key must hold a level before it is accepted (20 ms at 50 MHz).
- SYNC_STAGES, 2: flip-flop stages in each input synchronizer (minimum 2).
- CLK_HIGH_CYCLES, 4: cycles cpu_clk stays high per pulse (minimum 1).
- CLK_LOW_CYCLES, 4: minimum cycles cpu_clk stays low before the next pulse (minimum 1).
- BASE_PERIOD, 50_000_000: auto-run period in cycles at rate_sel=0.
- STEP_W, 16: width of step_count.

Ports:
- clk, input, 1: CLOCK_50 domain clock.
- reset, input, 1: synchronous, active-high reset.
- key_n, input, 1: raw step key, active-low, asynchronous.
- run_en, input, 1: raw switch, asynchronous; 1 = auto-run.
- rate_sel, input, 3: auto-run rate; period = BASE_PERIOD >> rate_sel.
- cpu_clk, output, 1: registered processor clock.
- step_pulse, output, 1: 1-cycle strobe on each cpu_clk rising edge.
- busy, output, 1: high while a pulse is in its HIGH or LOW_HOLD phase.
- step_count, output, STEP_W: number of issued pulses.

Behaviour:
- Reset: every output is 0.
  - Debounced key state = released (1); synchronizer flops = 1 for the key, 0 for run_en.
  - Auto-run divider = 0; pending request = 0; FSM = IDLE.
  - Reset asserted mid-pulse forces cpu_clk low on the next edge.
- Synchronizers: key_n and run_en each pass through SYNC_STAGES flops. rate_sel is quasi-static and is used unsynchronized.
- Debounce:
  - Counter clears whenever the synchronized key equals the stable state.
  - Otherwise the counter increments; at DEBOUNCE_CYCLES-1 the stable state flips and the counter clears.
  - A press event is a stable 1->0 transition and lasts 1 cycle. Release generates nothing.
- Auto-run:
  - When synced run_en=1, the divider counts 0..(BASE_PERIOD>>rate_sel)-1 and emits a tick at the terminal count, then wraps to 0.
  - Divider is held at 0 while run_en=0.
  - A rate_sel change takes effect at the next wrap. If the divider already exceeds the new terminal count, it wraps at its width-independent compare, using >=.
- Request source:
  - run_en=0: press events are requests.
  - run_en=1: ticks are requests and press events are ignored.
- Pending request:
  - One-deep pending flag, set by a request arriving while busy.
  - Further requests while the flag is set are dropped.
- FSM, with counter phase_cnt:
  - IDLE: on a request or pending flag: go to HIGH, cpu_clk<=1, step_pulse<=1 for that cycle, step_count+=1 (wraps at 2^STEP_W), and clear pending if it was used.
  - HIGH: after CLK_HIGH_CYCLES cycles at cpu_clk=1, go to LOW_HOLD with cpu_clk<=0.
  - LOW_HOLD: after CLK_LOW_CYCLES cycles, return to IDLE.
  - Back-to-back pulses: a request in the final LOW_HOLD cycle is registered as pending, giving pulse period = CLK_HIGH_CYCLES+CLK_LOW_CYCLES+1.
- busy = (state != IDLE).
- Glitch-free: cpu_clk comes directly from a flop, never from combinational logic.
- A run_en change mid-pulse does not truncate the current pulse. The pending flag is kept across the change.

Decomposition:
- Package step_clock_pkg:
  - state_t enum: IDLE, HIGH, LOW_HOLD.
  - localparam helpers for counter widths ($clog2 of DEBOUNCE_CYCLES, BASE_PERIOD, max(CLK_HIGH_CYCLES, CLK_LOW_CYCLES)).
- Sub-module key_debounce (synchronizer + debounce counter + press strobe), parameterized by DEBOUNCE_CYCLES and SYNC_STAGES.
- The run_en synchronizer is reused from key_debounce's internal synchronizer or written as a small flop chain.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, SYNC_STAGES=2, CLK_HIGH_CYCLES=2, CLK_LOW_CYCLES=2, BASE_PERIOD=64):
- Reset: hold reset 3 cycles with key_n=0 -> cpu_clk=0, step_pulse=0, busy=0, step_count=0 throughout; no pulse at release unless key_n stays 0 for 4 more stable cycles after sync.
- Single clean press: key_n low for 20 cycles, run_en=0 -> exactly one step_pulse, 2+4 cycles after the key falls (sync + debounce); cpu_clk high 2 cycles then low; step_count=1.
- Bouncy press: key_n toggling every 2 cycles for 12 cycles, then low 20 cycles -> exactly one pulse, issued only after the stable low period; step_count=1.
- Auto-run: run_en=1, rate_sel=2 -> ticks every 16 cycles and one pulse per tick; step_count=4 after 64 cycles plus sync latency; key presses in this interval cause no extra pulses.
- Back-to-back and pending: run_en=1, rate_sel=6 (period 1) -> pulses every 5 cycles, with at most one pending request; step_count wraps 0xFFFF->0x0000 when preloaded near max via a forced pulse count.
- Reset mid-pulse: reset asserted on the 2nd HIGH cycle -> cpu_clk=0 and busy=0 on the next edge; the pending request is discarded and no pulse follows.
